// File: rtl/cond_pkg.sv
// Shared types and constants for the execute-stage condition unit.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Flags are written in two groups: {N,Z} and {C,V}
    localparam int FLAG_GRP_W = 2;

    typedef enum logic {
        IT_IDLE   = 1'b0,
        IT_ACTIVE = 1'b1
    } it_state_e;

endpackage

// File: rtl/cond_unit_it_cond_eval.sv
// Pure combinational ARM condition check: 4-bit condition plus NZCV -> pass.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit_it.sv
// Execute-stage condition unit: NZCV register, control gating and an
// IT-style sequencer that supplies conditions for a short predicated block.
module cond_unit_it
    import cond_pkg::*;
#(
    parameter int MAX_IT = 4,
    parameter int LEN_W  = $clog2(MAX_IT + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ValidE,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic [3:0]        CondE,
    input  logic              ITStartE,
    input  logic [LEN_W-1:0]  ITLenE,
    input  logic [MAX_IT-1:0] ITMaskE,
    input  logic [1:0]        FlagWriteE,
    input  logic [3:0]        ALUFlags,
    input  logic              PCSrcEIn,
    input  logic              RegWriteEIn,
    input  logic              MemWriteEIn,
    input  logic              BranchEIn,
    input  logic              NoWrite,
    output logic              PCSrcE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              BranchE,
    output logic              CondExE,
    output logic [3:0]        Flags,
    output logic              ITActive,
    output logic [LEN_W-1:0]  ITRemain,
    output logic              ITErr
);

    it_state_e         state_q, state_d;
    logic [3:0]        base_q, base_d;
    logic [MAX_IT-1:0] mask_q, mask_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [LEN_W-1:0]  slot_q, slot_d;
    logic              err_q, err_d;
    logic [3:0]        flags_q;

    logic              advance;
    logic              bad_start;
    logic [MAX_IT-1:0] mask_sh;
    logic [3:0]        eff_cond;
    logic              cond_pass;
    logic              pass;

    assign advance   = ValidE & ~StallE & ~FlushE;
    assign bad_start = (state_q == IT_ACTIVE) || (ITLenE == '0) || (ITLenE > LEN_W'(MAX_IT));

    // Inside a block the slot's mask bit picks base or its inverse; the
    // block-start instruction itself always runs as AL.
    always_comb begin
        mask_sh = mask_q >> slot_q;
        if (ITStartE)
            eff_cond = COND_AL;
        else if (state_q == IT_ACTIVE)
            eff_cond = mask_sh[0] ? base_q : {base_q[3:1], ~base_q[0]};
        else
            eff_cond = CondE;
    end

    cond_eval u_cond_eval (
        .cond  (eff_cond),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    assign CondExE   = cond_pass;
    assign pass      = ValidE & ~FlushE & cond_pass & ~ITStartE;
    assign RegWriteE = RegWriteEIn & pass & ~NoWrite;
    assign MemWriteE = MemWriteEIn & pass;
    assign PCSrcE    = PCSrcEIn & pass;
    assign BranchE   = BranchEIn & pass;

    assign Flags    = flags_q;
    assign ITActive = (state_q == IT_ACTIVE);
    assign ITRemain = remain_q;
    assign ITErr    = err_q;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        mask_d   = mask_q;
        remain_d = remain_q;
        slot_d   = slot_q;
        err_d    = 1'b0;
        if (FlushE) begin
            state_d  = IT_IDLE;
            remain_d = '0;
            slot_d   = '0;
        end else if (advance) begin
            if (ITStartE) begin
                // An illegal start is a no-op and does not consume a slot
                if (bad_start) begin
                    err_d = 1'b1;
                end else begin
                    state_d  = IT_ACTIVE;
                    base_d   = CondE;
                    mask_d   = ITMaskE;
                    remain_d = ITLenE;
                    slot_d   = '0;
                end
            end else if (state_q == IT_ACTIVE) begin
                slot_d   = slot_q + 1'b1;
                remain_d = remain_q - 1'b1;
                if (remain_q == LEN_W'(1)) begin
                    state_d = IT_IDLE;
                    slot_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state_q <= IT_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            base_q   <= '0;
            mask_q   <= '0;
            remain_q <= '0;
            slot_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            base_q   <= base_d;
            mask_q   <= mask_d;
            remain_q <= remain_d;
            slot_q   <= slot_d;
            err_q    <= err_d;
        end
    end

    // Flags written this cycle only become visible to the next instruction
    always_ff @(posedge CLK) begin
        if (RESET) begin
            flags_q <= '0;
        end else if (advance && cond_pass && !ITStartE) begin
            if (FlagWriteE[1])
                flags_q[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            if (FlagWriteE[0])
                flags_q[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
        end
    end

endmodule

// File: tb/tb_cond_unit_it.sv
// Directed self-checking bench for cond_unit_it (MAX_IT=4).
module tb_cond_unit_it;

    localparam int MAX_IT = 4;
    localparam int LEN_W  = $clog2(MAX_IT + 1);

    logic              CLK = 1'b0;
    logic              RESET;
    logic              ValidE, StallE, FlushE;
    logic [3:0]        CondE;
    logic              ITStartE;
    logic [LEN_W-1:0]  ITLenE;
    logic [MAX_IT-1:0] ITMaskE;
    logic [1:0]        FlagWriteE;
    logic [3:0]        ALUFlags;
    logic              PCSrcEIn, RegWriteEIn, MemWriteEIn, BranchEIn, NoWrite;
    logic              PCSrcE, RegWriteE, MemWriteE, BranchE, CondExE;
    logic [3:0]        Flags;
    logic              ITActive;
    logic [LEN_W-1:0]  ITRemain;
    logic              ITErr;

    int n_checks = 0;
    int n_fails  = 0;

    cond_unit_it #(.MAX_IT(MAX_IT)) dut (
        .CLK(CLK), .RESET(RESET), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
        .CondE(CondE), .ITStartE(ITStartE), .ITLenE(ITLenE), .ITMaskE(ITMaskE),
        .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags), .PCSrcEIn(PCSrcEIn),
        .RegWriteEIn(RegWriteEIn), .MemWriteEIn(MemWriteEIn), .BranchEIn(BranchEIn),
        .NoWrite(NoWrite), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .CondExE(CondExE), .Flags(Flags), .ITActive(ITActive),
        .ITRemain(ITRemain), .ITErr(ITErr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle so registered outputs can be sampled
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Plain valid instruction with all controls cleared
    task automatic instr(input logic [3:0] c);
        ValidE = 1'b1; StallE = 1'b0; FlushE = 1'b0; CondE = c;
        ITStartE = 1'b0; ITLenE = '0; ITMaskE = '0; FlagWriteE = 2'b00; ALUFlags = 4'h0;
        PCSrcEIn = 1'b0; RegWriteEIn = 1'b0; MemWriteEIn = 1'b0; BranchEIn = 1'b0; NoWrite = 1'b0;
    endtask

    task automatic it_start(input logic [3:0] c, input logic [LEN_W-1:0] len, input logic [MAX_IT-1:0] m);
        instr(c);
        ITStartE = 1'b1; ITLenE = len; ITMaskE = m;
        RegWriteEIn = 1'b1; PCSrcEIn = 1'b1;
    endtask

    initial begin
        instr(4'hE);
        ValidE = 1'b0;
        RESET = 1'b1;
        tick(); tick();
        RESET = 1'b0;
        #1;
        chk("rst_flags", Flags, 4'h0);
        chk("rst_active", ITActive, 1'b0);
        chk("rst_remain", ITRemain, 0);
        chk("rst_err", ITErr, 1'b0);

        // CMP-style: sets Z, writes no register
        instr(4'hE); FlagWriteE = 2'b11; ALUFlags = 4'b0100; NoWrite = 1'b1; RegWriteEIn = 1'b1;
        #1;
        chk("cmp_regwrite", RegWriteE, 1'b0);
        chk("cmp_condex", CondExE, 1'b1);
        tick();
        chk("cmp_flags", Flags, 4'b0100);

        instr(4'h0); RegWriteEIn = 1'b1; MemWriteEIn = 1'b1; BranchEIn = 1'b1;
        #1;
        chk("eq_regwrite", RegWriteE, 1'b1);
        chk("eq_memwrite", MemWriteE, 1'b1);
        chk("eq_branch", BranchE, 1'b1);
        tick();
        instr(4'h1); RegWriteEIn = 1'b1;
        #1;
        chk("ne_regwrite", RegWriteE, 1'b0);
        tick();

        // IT EQ, len 3, mask 0101 -> slots pass, fail, pass
        it_start(4'h0, 3, 4'b0101);
        #1;
        chk("it_self_regwrite", RegWriteE, 1'b0);
        chk("it_self_pcsrc", PCSrcE, 1'b0);
        tick();
        chk("it_active", ITActive, 1'b1);
        chk("it_remain3", ITRemain, 3);
        instr(4'hE); RegWriteEIn = 1'b1;
        #1;
        chk("slot0_regwrite", RegWriteE, 1'b1);
        tick();
        chk("it_remain2", ITRemain, 2);
        StallE = 1'b1;
        #1;
        chk("slot1_stall_a", RegWriteE, 1'b0);
        tick();
        chk("stall_remain_a", ITRemain, 2);
        chk("stall_condex_a", CondExE, 1'b0);
        tick();
        chk("stall_remain_b", ITRemain, 2);
        StallE = 1'b0;
        #1;
        chk("slot1_regwrite", RegWriteE, 1'b0);
        tick();
        chk("it_remain1", ITRemain, 1);
        chk("it_active_mid", ITActive, 1'b1);
        #1;
        chk("slot2_regwrite", RegWriteE, 1'b1);
        tick();
        chk("it_remain0", ITRemain, 0);
        chk("it_done", ITActive, 1'b0);

        // Partial flag-group writes and a failing condition
        instr(4'hE); FlagWriteE = 2'b11; ALUFlags = 4'h0;
        tick();
        chk("clr_flags", Flags, 4'h0);
        instr(4'hE); FlagWriteE = 2'b10; ALUFlags = 4'hF;
        tick();
        chk("nz_write", Flags, 4'b1100);
        instr(4'h1); FlagWriteE = 2'b11; ALUFlags = 4'b0011;
        #1;
        chk("ne_fail_condex", CondExE, 1'b0);
        tick();
        chk("fail_no_flagwr", Flags, 4'b1100);

        // Flush in slot 2 of a 4-long MI block (N=1)
        it_start(4'h4, 4, 4'b1111);
        tick();
        chk("blk4_remain", ITRemain, 4);
        instr(4'hE);
        tick();
        tick();
        chk("blk4_slot2_remain", ITRemain, 2);
        instr(4'hE); FlushE = 1'b1; RegWriteEIn = 1'b1; FlagWriteE = 2'b11; ALUFlags = 4'h0;
        #1;
        chk("flush_regwrite", RegWriteE, 1'b0);
        tick();
        chk("flush_active", ITActive, 1'b0);
        chk("flush_remain", ITRemain, 0);
        chk("flush_flags", Flags, 4'b1100);
        instr(4'h5); RegWriteEIn = 1'b1;
        #1;
        chk("post_flush_pl", RegWriteE, 1'b0);
        CondE = 4'h4;
        #1;
        chk("post_flush_mi", RegWriteE, 1'b1);
        tick();

        // Illegal starts
        it_start(4'hE, 0, 4'b1111);
        tick();
        chk("len0_err", ITErr, 1'b1);
        chk("len0_active", ITActive, 1'b0);
        chk("len0_remain", ITRemain, 0);
        it_start(4'hE, 5, 4'b1111);
        tick();
        chk("len5_err", ITErr, 1'b1);
        chk("len5_active", ITActive, 1'b0);
        it_start(4'hE, 2, 4'b0011);
        tick();
        chk("legal_err", ITErr, 1'b0);
        chk("legal_remain", ITRemain, 2);
        it_start(4'hE, 1, 4'b0000);
        #1;
        chk("nested_regwrite", RegWriteE, 1'b0);
        tick();
        chk("nested_err", ITErr, 1'b1);
        chk("nested_remain", ITRemain, 2);
        chk("nested_active", ITActive, 1'b1);
        instr(4'h1); RegWriteEIn = 1'b1;
        #1;
        chk("after_nested_slot0", RegWriteE, 1'b1);
        tick();
        chk("after_nested_err", ITErr, 1'b0);
        chk("after_nested_remain", ITRemain, 1);

        // Reset mid-block
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("midrst_active", ITActive, 1'b0);
        chk("midrst_flags", Flags, 4'h0);
        chk("midrst_remain", ITRemain, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
